// File: rtl/ysyx_24070014_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and
// hands the fetched word with its PC to decode over a valid/ready channel.
module ysyx_24070014_ifu #(
  parameter int unsigned ADDR_LEN = 32,
  parameter int unsigned INST_LEN = 32,
  parameter logic [ADDR_LEN-1:0] INIT_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  output logic [ADDR_LEN-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_resp_valid,
  input  logic [INST_LEN-1:0] imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  output logic                fetch_misaligned
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, VALID} state_t;

  state_t              state, state_next;
  logic [ADDR_LEN-1:0] pc, pc_next;
  logic                stale, stale_next;
  logic [INST_LEN-1:0] inst_next;
  logic [ADDR_LEN-1:0] inst_pc_next;
  logic                misaligned_next;
  logic                redirect_act;

  assign imem_req_valid = (state == FETCH);
  assign inst_valid     = (state == VALID);
  assign imem_req_addr  = pc;
  assign redirect_act   = redirect_valid && (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= INIT_PC;
      stale            <= 1'b0;
      inst             <= '0;
      inst_pc          <= INIT_PC;
      fetch_misaligned <= 1'b0;
    end else begin
      state            <= state_next;
      pc               <= pc_next;
      stale            <= stale_next;
      inst             <= inst_next;
      inst_pc          <= inst_pc_next;
      fetch_misaligned <= misaligned_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    stale_next      = stale;
    inst_next       = inst;
    inst_pc_next    = inst_pc;
    misaligned_next = 1'b0;

    case (state)
      IDLE: state_next = FETCH;
      FETCH: begin
        // A redirect coinciding with acceptance leaves an in-flight read for the old PC.
        if (imem_req_ready) begin
          state_next = WAIT;
          if (redirect_valid) stale_next = 1'b1;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid || stale) begin
            stale_next = 1'b0;
            state_next = FETCH;
          end else begin
            inst_next    = imem_resp_data;
            inst_pc_next = pc;
            state_next   = VALID;
          end
        end else if (redirect_valid) begin
          stale_next = 1'b1;
        end
      end
      VALID: begin
        if (redirect_valid) begin
          state_next = FETCH;
        end else if (inst_ready) begin
          pc_next    = pc + ADDR_LEN'(4);
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect wins over sequential PC advance; low bits are dropped, not trapped.
    if (redirect_act) begin
      pc_next         = {redirect_pc[ADDR_LEN-1:2], 2'b00};
      misaligned_next = |redirect_pc[1:0];
    end
  end

endmodule

// File: tb/tb_ysyx_24070014_ifu.sv
// Bench for ysyx_24070014_ifu: directed per-cycle vector table, hand-written
// reset/wrap sequences, then random traffic against a transaction-level model.
module tb_ysyx_24070014_ifu;

  localparam logic [31:0] B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_misaligned;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24070014_ifu dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  typedef struct {
    logic        rr, rv;
    logic [31:0] rd;
    logic        ir, rdv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic rr, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic rdv, input logic [31:0] rpc,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_iv, input logic [31:0] e_inst,
                     input logic [31:0] e_ipc, input logic e_mis);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.rdv = rdv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_mis = e_mis;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic rdv, input logic [31:0] rpc);
    imem_req_ready  = rr;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    inst_ready      = ir;
    redirect_valid  = rdv;
    redirect_pc     = rpc;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  initial begin
    // Directed vectors: one row per cycle, outputs checked at the negedge.
    row(0,0,0,         0,0,0,          0,0,      0,0,0,0);
    row(1,0,0,         0,0,0,          1,B,      0,0,0,0);
    row(0,1,32'h13,    0,0,0,          0,0,      0,0,0,0);
    row(0,0,0,         1,0,0,          0,0,      1,32'h13,B,0);
    row(1,0,0,         0,0,0,          1,B+4,    0,0,0,0);
    row(0,1,32'h13,    0,0,0,          0,0,      0,0,0,0);
    row(0,0,0,         1,0,0,          0,0,      1,32'h13,B+4,0);
    row(1,0,0,         0,0,0,          1,B+8,    0,0,0,0);
    row(0,1,32'h00100093,0,0,0,        0,0,      0,0,0,0);
    for (int i = 0; i < 5; i++)
      row(0,0,0,       0,0,0,          0,0,      1,32'h00100093,B+8,0);
    row(0,0,0,         1,0,0,          0,0,      1,32'h00100093,B+8,0);
    row(1,0,0,         0,0,0,          1,B+12,   0,0,0,0);
    row(0,0,0,         0,1,B+32'h100,  0,0,      0,0,0,0);
    row(0,0,0,         0,0,0,          0,0,      0,0,0,0);
    row(0,0,0,         0,0,0,          0,0,      0,0,0,0);
    row(0,1,32'h13,    0,0,0,          0,0,      0,0,0,0);
    row(1,0,0,         0,0,0,          1,B+32'h100,0,0,0,0);
    row(0,1,32'h33,    0,0,0,          0,0,      0,0,0,0);
    row(0,0,0,         1,1,B+32'h40,   0,0,      1,32'h33,B+32'h100,0);
    row(0,0,0,         0,1,B+32'h102,  1,B+32'h40,0,0,0,0);
    row(0,0,0,         0,0,0,          1,B+32'h100,0,0,0,1);
    row(1,0,0,         0,0,0,          1,B+32'h100,0,0,0,0);
    row(0,1,32'h13,    0,0,0,          0,0,      0,0,0,0);
    row(0,0,0,         0,1,B+32'h200,  0,0,      1,32'h13,B+32'h100,0);
    row(1,0,0,         0,1,B+32'h300,  1,B+32'h200,0,0,0,0);
    row(0,1,32'h13,    0,0,0,          0,0,      0,0,0,0);
    row(1,0,0,         0,0,0,          1,B+32'h300,0,0,0,0);
    row(0,1,32'h13,    0,1,B+32'h401,  0,0,      0,0,0,0);
    row(0,0,0,         0,0,0,          1,B+32'h400,0,0,0,1);
    row(0,0,0,         0,0,0,          1,B+32'h400,0,0,0,0);

    repeat (3) @(negedge clk);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 0);
    checkOutput("rst_addr", imem_req_addr, B);
    checkOutput("rst_inst_pc", inst_pc, B);
    checkOutput("rst_inst", inst, 0);
    checkOutput("rst_mis", {31'b0, fetch_misaligned}, 0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].rdv, vecs[i].rpc);
      checkOutput($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vecs[i].e_req});
      checkOutput($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].e_iv});
      checkOutput($sformatf("v%0d_mis", i), {31'b0, fetch_misaligned}, {31'b0, vecs[i].e_mis});
      if (vecs[i].e_req) checkOutput($sformatf("v%0d_addr", i), imem_req_addr, vecs[i].e_addr);
      if (vecs[i].e_iv) begin
        checkOutput($sformatf("v%0d_inst", i), inst, vecs[i].e_inst);
        checkOutput($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_ipc);
      end
      @(negedge clk);
    end

    // PC wrap: redirect to the last word, consume it, next fetch is address 0.
    applyStimulus(0,0,0,0,1,32'hFFFF_FFFC); @(negedge clk);
    checkOutput("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    applyStimulus(1,0,0,0,0,0); @(negedge clk);
    applyStimulus(0,1,32'h0000_0073,0,0,0); @(negedge clk);
    checkOutput("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    applyStimulus(0,0,0,1,0,0); @(negedge clk);
    checkOutput("wrap_next_addr", imem_req_addr, 32'h0);
    applyStimulus(1,0,0,0,0,0); @(negedge clk);

    // Reset mid-WAIT, then a late response while IDLE must be ignored.
    applyStimulus(0,0,0,0,0,0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_req_valid", {31'b0, imem_req_valid}, 0);
    checkOutput("midrst_inst_valid", {31'b0, inst_valid}, 0);
    checkOutput("midrst_addr", imem_req_addr, B);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0,1,32'hDEAD_BEEF,1,0,0);
    checkOutput("idle_req_valid", {31'b0, imem_req_valid}, 0);
    @(negedge clk);
    applyStimulus(1,0,0,1,0,0);
    checkOutput("post_rst_req_valid", {31'b0, imem_req_valid}, 1);
    checkOutput("post_rst_addr", imem_req_addr, B);
    checkOutput("post_rst_inst_valid", {31'b0, inst_valid}, 0);
    @(negedge clk);
    applyStimulus(0,1,32'h13,0,0,0);
    checkOutput("post_rst_wait_iv", {31'b0, inst_valid}, 0);
    @(negedge clk);
    applyStimulus(0,0,0,0,0,0);
    checkOutput("post_rst_iv", {31'b0, inst_valid}, 1);
    checkOutput("post_rst_inst", inst, 32'h13);
    checkOutput("post_rst_inst_pc", inst_pc, B);

    randomPhase();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Model: next_pc is the PC decode should see next; memory returns memf(addr)
  // 1..3 cycles after acceptance and holds at most one read in flight.
  task automatic randomPhase();
    logic [31:0] next_pc = B;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr = '0;
    logic        exp_mis = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] hold_inst = '0, hold_pc = '0;
    int          idle = 0, delivered = 0;
    logic        rr, rv, ir, rdv, pend_start;
    logic [31:0] rd, rpc;

    applyStimulus(0,0,0,0,0,0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      pend_start = pend;
      rv = 1'b0; rd = '0;
      if (pend) begin
        if (cnt == 0) begin rv = 1'b1; rd = memf(pend_addr); pend = 1'b0; end
        else cnt--;
      end
      rr  = ($urandom_range(0, 2) != 0);
      ir  = ($urandom_range(0, 2) != 0);
      rdv = (cyc >= 2) && ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      applyStimulus(rr, rv, rd, ir, rdv, rpc);

      checkOutput("rand_mis", {31'b0, fetch_misaligned}, {31'b0, exp_mis});
      if (hold) begin
        checkOutput("rand_hold_iv", {31'b0, inst_valid}, 1);
        checkOutput("rand_hold_inst", inst, hold_inst);
        checkOutput("rand_hold_pc", inst_pc, hold_pc);
      end
      if (imem_req_valid) begin
        checkOutput("rand_req_addr", imem_req_addr, next_pc);
        checkOutput("rand_one_outstanding", {31'b0, pend_start}, 0);
        if (rr) begin
          pend = 1'b1; cnt = $urandom_range(0, 2); pend_addr = imem_req_addr;
        end
      end
      idle++;
      if (inst_valid && ir) begin
        checkOutput("rand_inst_pc", inst_pc, next_pc);
        checkOutput("rand_inst", inst, memf(inst_pc));
        next_pc = next_pc + 32'd4;
        idle = 0;
        delivered++;
      end
      hold = inst_valid && !ir && !rdv;
      hold_inst = inst; hold_pc = inst_pc;
      exp_mis = rdv && (rpc[1:0] != 2'b00);
      if (rdv) next_pc = {rpc[31:2], 2'b00};
      if (idle > 300) begin
        checkOutput("rand_liveness", 0, 1);
        break;
      end
      @(negedge clk);
    end
    checkOutput("rand_progress", {31'b0, delivered > 100}, 1);
  endtask

endmodule
